var_bw_div: RTL



---
 rtl/var_bw_pkg.sv | 17 +
 rtl/var_bw_sub.sv | 29 ++
 rtl/var_bw_div.sv | 121 ++++++++++++
 3 files changed

// File: rtl/var_bw_pkg.sv
// Shared definitions for the variable bit-width arithmetic datapath:
// FSM states, default widths and the mode-select encoding.
package var_bw_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam int unsigned DEF_W  = 16;
    localparam int unsigned DEF_HW = DEF_W / 2;

    localparam logic PARA = 1'b1;
    localparam logic FULL = 1'b0;

endpackage

// File: rtl/var_bw_sub.sv
// Combinational variable bit-width subtractor over two (W/2+1)-bit lanes.
// In para mode the borrow between the lanes is cut; otherwise they form one wide subtraction.
module var_bw_sub
    import var_bw_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic         para_mode,
    input  logic [W+1:0] x,
    input  logic [W+1:0] y,
    output logic [W+1:0] diff,
    output logic [1:0]   borrow
);

    localparam int unsigned HW = W / 2;

    logic [HW+1:0] lo;
    logic [HW+1:0] hi;
    logic          cin_hi;

    always_comb begin
        lo     = {1'b0, x[HW:0]} - {1'b0, y[HW:0]};
        cin_hi = (para_mode == PARA) ? 1'b0 : lo[HW+1];
        hi     = {1'b0, x[W+1:HW+1]} - {1'b0, y[W+1:HW+1]} - {{(HW+1){1'b0}}, cin_hi};
        diff   = {hi[HW:0], lo[HW:0]};
        borrow = (para_mode == PARA) ? {hi[HW+1], lo[HW+1]} : {1'b0, hi[HW+1]};
    end

endmodule

// File: rtl/var_bw_div.sv
// Iterative restoring unsigned divider: one W-bit divide or two W/2-bit lane
// divides, one quotient bit per lane per cycle, valid/ready on both sides.
module var_bw_div
    import var_bw_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         para_mode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic [1:0]   dz
);

    localparam int unsigned HW = W / 2;
    localparam int unsigned CW = $clog2(W + 1);
    localparam logic [CW-1:0] N_FULL = CW'(W);
    localparam logic [CW-1:0] N_PARA = CW'(HW);

    state_t        state;
    logic          mode_r;
    logic [W-1:0]  aq;      // dividend shifts out the top, quotient bits shift in the bottom
    logic [W-1:0]  rem;
    logic [W-1:0]  dvs;
    logic [CW-1:0] cnt;

    logic [W+1:0]  sub_x;
    logic [W+1:0]  sub_y;
    logic [W+1:0]  sub_d;
    logic [1:0]    bw;
    logic [W-1:0]  aq_nxt;
    logic [W-1:0]  rem_nxt;
    logic [1:0]    dz_calc;
    logic          unused_bits;

    var_bw_sub #(.W(W)) u_sub (
        .para_mode (mode_r),
        .x         (sub_x),
        .y         (sub_y),
        .diff      (sub_d),
        .borrow    (bw)
    );

    // Para mode packs each lane as {partial remainder, next dividend bit} in W/2+1 bits.
    always_comb begin
        if (mode_r == PARA) begin
            sub_x   = {rem[W-1:HW], aq[W-1], rem[HW-1:0], aq[HW-1]};
            sub_y   = {1'b0, dvs[W-1:HW], 1'b0, dvs[HW-1:0]};
            rem_nxt = {bw[1] ? sub_x[W:HW+1] : sub_d[W:HW+1],
                       bw[0] ? sub_x[HW-1:0] : sub_d[HW-1:0]};
            aq_nxt  = {aq[W-2:HW], ~bw[1], aq[HW-2:0], ~bw[0]};
            dz_calc = {dvs[W-1:HW] == '0, dvs[HW-1:0] == '0};
        end else begin
            sub_x   = {1'b0, rem, aq[W-1]};
            sub_y   = {2'b00, dvs};
            rem_nxt = bw[0] ? sub_x[W-1:0] : sub_d[W-1:0];
            aq_nxt  = {aq[W-2:0], ~bw[0]};
            dz_calc = {1'b0, dvs == '0};
        end
    end

    assign unused_bits = ^{sub_d[W+1], sub_d[HW]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            q         <= '0;
            r         <= '0;
            dz        <= '0;
            mode_r    <= FULL;
            aq        <= '0;
            rem       <= '0;
            dvs       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        aq       <= a;
                        dvs      <= b;
                        mode_r   <= para_mode;
                        rem      <= '0;
                        cnt      <= (para_mode == PARA) ? N_PARA : N_FULL;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    aq  <= aq_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        q         <= aq_nxt;
                        r         <= rem_nxt;
                        dz        <= dz_calc;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
